led_value_mapper: RTL and testbench

Front-end stage feeding `led_bar`. Accepts raw unsigned sensor samples on a valid strobe and smooths them with a shift-based exponential moving average. It maps the filtered reading to an LED index through a bit-serial divider and produces the bar's `value` and `blink` inputs, plus a decaying peak-hold index for a second bar.

---
 rtl/led_value_mapper.sv | 185 ++++++++++++++++++
 tb/tb_led_value_mapper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led_value_mapper.sv
// Sensor front end for led_bar: EMA smoothing, bit-serial divide to an LED index,
// hysteretic blink flag and a decaying peak-hold index.
module led_value_mapper #(
    parameter int IN_BITS    = 12,
    parameter int VAL_BITS   = 3,
    parameter int VAL_L      = 0,
    parameter int VAL_U      = 7,
    parameter int IN_MIN     = 0,
    parameter int STEP       = 512,
    parameter int FILT_SHIFT = 2,
    parameter int WARN_HI    = 3584,
    parameter int WARN_LO    = 3072,
    parameter int HOLD_CLKS  = 16,
    parameter int HOLD_BITS  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_BITS-1:0]  sample,
    input  logic                sample_valid,
    output logic                ready,
    output logic [VAL_BITS-1:0] value,
    output logic                value_valid,
    output logic                blink,
    output logic [VAL_BITS-1:0] peak
);

    localparam int CNT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam logic [HOLD_BITS-1:0] HOLD_RELOAD = HOLD_BITS'(HOLD_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILTER,
        S_DIVIDE,
        S_OUTPUT
    } state_t;

    state_t               state_q, state_d;
    logic [IN_BITS-1:0]   sample_q, sample_d;
    logic [IN_BITS-1:0]   acc_q, acc_d;
    logic                 first_q, first_d;
    logic [IN_BITS-1:0]   num_q, num_d;
    logic [IN_BITS:0]     rem_q, rem_d;
    logic [IN_BITS-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VAL_BITS-1:0]  value_q, value_d;
    logic                 blink_q, blink_d;
    logic                 valid_q, valid_d;
    logic [VAL_BITS-1:0]  peak_q, peak_d;
    logic [HOLD_BITS-1:0] hold_q, hold_d;

    logic [IN_BITS-1:0]   acc_new;
    logic [IN_BITS:0]     off_diff;
    logic [IN_BITS:0]     rem_shift;
    logic                 rem_ge;
    logic [VAL_BITS-1:0]  idx;

    // Floor-shift EMA; the signed difference keeps the result inside [0, 2^IN_BITS-1].
    function automatic logic [IN_BITS-1:0] ema_step(input logic [IN_BITS-1:0] acc,
                                                    input logic [IN_BITS-1:0] smp);
        logic signed [IN_BITS+1:0] diff;
        logic signed [IN_BITS+1:0] sum;
        diff = $signed({2'b00, smp}) - $signed({2'b00, acc});
        sum  = $signed({2'b00, acc}) + (diff >>> FILT_SHIFT);
        return sum[IN_BITS-1:0];
    endfunction

    function automatic logic [VAL_BITS-1:0] clamp_idx(input logic [IN_BITS-1:0] q);
        logic [IN_BITS:0] w;
        w = {1'b0, q} + (IN_BITS+1)'(VAL_L);
        if (w > (IN_BITS+1)'(VAL_U)) begin
            return VAL_BITS'(VAL_U);
        end
        return w[VAL_BITS-1:0];
    endfunction

    assign acc_new   = first_q ? sample_q : ema_step(acc_q, sample_q);
    assign off_diff  = {1'b0, acc_new} - (IN_BITS+1)'(IN_MIN);
    assign rem_shift = {rem_q[IN_BITS-1:0], num_q[cnt_q]};
    assign rem_ge    = (rem_shift >= (IN_BITS+1)'(STEP));
    assign idx       = clamp_idx(quo_q);

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        acc_d    = acc_q;
        first_d  = first_q;
        num_d    = num_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        blink_d  = blink_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    sample_d = sample;
                    state_d  = S_FILTER;
                end
            end
            S_FILTER: begin
                acc_d   = acc_new;
                first_d = 1'b0;
                num_d   = off_diff[IN_BITS] ? '0 : off_diff[IN_BITS-1:0];
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = CNT_W'(IN_BITS - 1);
                state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                rem_d = rem_ge ? (rem_shift - (IN_BITS+1)'(STEP)) : rem_shift;
                quo_d = {quo_q[IN_BITS-2:0], rem_ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                value_d = idx;
                if (acc_q >= IN_BITS'(WARN_HI)) begin
                    blink_d = 1'b1;
                end else if (acc_q <= IN_BITS'(WARN_LO)) begin
                    blink_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Peak only decays down to the displayed value, one step per HOLD_CLKS clocks.
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if ((state_q == S_OUTPUT) && (idx > peak_q)) begin
            peak_d = idx;
            hold_d = HOLD_RELOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else if (peak_q > value_q) begin
            peak_d = peak_q - 1'b1;
            hold_d = HOLD_RELOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            first_q <= 1'b1;
            value_q <= VAL_BITS'(VAL_L);
            blink_q <= 1'b0;
            valid_q <= 1'b0;
            peak_q  <= VAL_BITS'(VAL_L);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            value_q <= value_d;
            blink_q <= blink_d;
            valid_q <= valid_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
        end
    end

    // Datapath scratch registers are always loaded before use, so they need no reset.
    always_ff @(posedge clk) begin
        sample_q <= sample_d;
        num_q    <= num_d;
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        cnt_q    <= cnt_d;
    end

    assign ready       = (state_q == S_IDLE);
    assign value       = value_q;
    assign value_valid = valid_q;
    assign blink       = blink_q;
    assign peak        = peak_q;

endmodule

// File: tb/tb_led_value_mapper.sv
// Directed bench for led_value_mapper: default instance plus an IN_MIN=1024, unfiltered instance.
module tb_led_value_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] sample_a, sample_b;
    logic        sv_a, sv_b;
    logic        ready_a, vv_a, blink_a;
    logic        ready_b, vv_b, blink_b;
    logic [2:0]  value_a, peak_a, value_b, peak_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_value_mapper dut_a (
        .clk(clk), .reset(reset), .sample(sample_a), .sample_valid(sv_a),
        .ready(ready_a), .value(value_a), .value_valid(vv_a), .blink(blink_a), .peak(peak_a)
    );

    led_value_mapper #(.IN_MIN(1024), .FILT_SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .sample(sample_b), .sample_valid(sv_b),
        .ready(ready_b), .value(value_b), .value_valid(vv_b), .blink(blink_b), .peak(peak_b)
    );

    typedef struct {
        bit          rst;
        logic [11:0] s;
        logic [2:0]  v;
        logic        bl;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic xfer(input bit sel, input logic [11:0] s, output int lat,
                        output logic [2:0] v, output logic bl, output logic [2:0] pk);
        int n;
        n = 0;
        while (!(sel ? ready_b : ready_a) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sel) begin sample_b = s; sv_b = 1'b1; end
        else     begin sample_a = s; sv_a = 1'b1; end
        @(posedge clk); #1;
        sv_a = 1'b0;
        sv_b = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (sel ? vv_b : vv_a) break;
        end
        v  = sel ? value_b : value_a;
        bl = sel ? blink_b : blink_a;
        pk = sel ? peak_b : peak_a;
    endtask

    initial begin
        int         lat, n, pulses;
        logic [2:0] v, pk, prev, seen_v;
        logic       bl, ok;

        tbl[0] = '{1'b1, 12'd1536, 3'd3, 1'b0};
        tbl[1] = '{1'b0, 12'd3584, 3'd4, 1'b0};
        tbl[2] = '{1'b0, 12'd0,    3'd3, 1'b0};
        tbl[3] = '{1'b1, 12'd4095, 3'd7, 1'b1};
        tbl[4] = '{1'b1, 12'd3600, 3'd7, 1'b1};
        tbl[5] = '{1'b0, 12'd2000, 3'd6, 1'b1};
        tbl[6] = '{1'b0, 12'd2688, 3'd6, 1'b0};
        tbl[7] = '{1'b0, 12'd4095, 3'd6, 1'b0};
        tbl[8] = '{1'b0, 12'd4019, 3'd6, 1'b0};
        tbl[9] = '{1'b0, 12'd4095, 3'd7, 1'b1};

        sample_a = '0; sample_b = '0; sv_a = 1'b0; sv_b = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst ready", ready_a, 1);
        check("rst value", value_a, 0);
        check("rst peak", peak_a, 0);
        check("rst blink", blink_a, 0);
        check("rst vvalid", vv_a, 0);
        @(posedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            xfer(1'b0, tbl[i].s, lat, v, bl, pk);
            check($sformatf("vec%0d latency", i), lat, 14);
            check($sformatf("vec%0d value", i), v, tbl[i].v);
            check($sformatf("vec%0d blink", i), bl, tbl[i].bl);
        end

        // Busy strobe is ignored: one pulse, value from the first sample only.
        do_reset();
        sample_a = 12'd1536; sv_a = 1'b1;
        @(posedge clk); #1 sv_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy ready", ready_a, 0);
        sample_a = 12'd4095; sv_a = 1'b1;
        @(posedge clk); #1 sv_a = 1'b0;
        pulses = 0; seen_v = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (vv_a) begin pulses++; seen_v = value_a; end
        end
        check("busy pulses", pulses, 1);
        check("busy value", seen_v, 3);

        // Strobe on the OUTPUT edge is dropped.
        sample_a = 12'd1536; sv_a = 1'b1;
        @(posedge clk); #1 sv_a = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        sample_a = 12'd4095; sv_a = 1'b1;
        @(posedge clk); #1 sv_a = 1'b0;
        check("outedge vvalid", vv_a, 1);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (vv_a) pulses++;
        end
        check("outedge dropped", pulses, 0);

        // Reset in the middle of DIVIDE.
        do_reset();
        xfer(1'b0, 12'd4095, lat, v, bl, pk);
        check("pre-rst peak", pk, 7);
        sample_a = 12'd1536; sv_a = 1'b1;
        @(posedge clk); #1 sv_a = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid ready", ready_a, 1);
        check("mid value", value_a, 0);
        check("mid peak", peak_a, 0);
        check("mid blink", blink_a, 0);
        check("mid vvalid", vv_a, 0);
        @(posedge clk); #1 reset = 1'b1;
        xfer(1'b0, 12'd1536, lat, v, bl, pk);
        check("post-rst value", v, 3);

        // Offset instance.
        xfer(1'b1, 12'd512, lat, v, bl, pk);
        check("min 512 value", v, 0);
        xfer(1'b1, 12'd1600, lat, v, bl, pk);
        check("min 1600 value", v, 1);

        // Peak decay with zeros fed continuously.
        do_reset();
        sample_a = 12'd4095; sv_a = 1'b1;
        @(posedge clk); #1 sample_a = 12'd0;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (vv_a) break;
        end
        check("peak latency", n, 14);
        check("peak initial", peak_a, 7);
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            prev = peak_a;
            n = 0;
            while (n < 40) begin
                @(posedge clk); #1;
                n++;
                if (peak_a < value_a) ok = 1'b0;
                if (peak_a != prev) break;
            end
            check($sformatf("peak interval%0d", k), n, 16);
            check($sformatf("peak level%0d", k), peak_a, 6 - k);
        end
        check("peak >= value", ok, 1);
        sv_a = 1'b0;
        repeat (20) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
